// File: rtl/xnor_frame_checker.sv
// Frame-level lane comparator: accumulates bitwise mismatches between lanes a and b
// over FRAME valid beats, with optional abort on the first mismatching beat.
module xnor_frame_checker #(
    parameter int WIDTH = 4,
    parameter int FRAME = 8,
    parameter int CW    = $clog2(WIDTH*FRAME+1),
    parameter int IW    = $clog2(FRAME)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] eq_bits,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [CW-1:0]    mismatches,
    output logic             err_seen,
    output logic [IW-1:0]    first_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] eq_bits_q, eq_bits_d;
    logic [CW-1:0]    mism_q, mism_d;
    logic             err_q, err_d;
    logic [IW-1:0]    first_q, first_d;
    logic             equal_q, equal_d;
    logic             mode_q, mode_d;
    logic [IW-1:0]    beat_q, beat_d;

    logic [WIDTH-1:0] diff;
    logic [CW-1:0]    mism_sum;

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    assign diff     = a ^ b;
    assign mism_sum = mism_q + popcount(diff);

    always_comb begin
        state_d   = state_q;
        eq_bits_d = eq_bits_q;
        mism_d    = mism_q;
        err_d     = err_q;
        first_d   = first_q;
        equal_d   = equal_q;
        mode_d    = mode_q;
        beat_d    = beat_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    eq_bits_d = '0;
                    mism_d    = '0;
                    err_d     = 1'b0;
                    first_d   = '0;
                    equal_d   = 1'b0;
                    beat_d    = '0;
                    mode_d    = mode;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (valid) begin
                    eq_bits_d = ~diff;
                    mism_d    = mism_sum;
                    beat_d    = beat_q + IW'(1);
                    if ((diff != '0) && !err_q) begin
                        err_d   = 1'b1;
                        first_d = beat_q;
                    end
                    // Frame ends on its last beat, or early on a mismatch in abort mode
                    if ((beat_q == IW'(FRAME-1)) || (mode_q && (diff != '0))) begin
                        state_d = DONE;
                        equal_d = (mism_sum == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            eq_bits_q <= '0;
            mism_q    <= '0;
            err_q     <= 1'b0;
            first_q   <= '0;
            equal_q   <= 1'b0;
            mode_q    <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            eq_bits_q <= eq_bits_d;
            mism_q    <= mism_d;
            err_q     <= err_d;
            first_q   <= first_d;
            equal_q   <= equal_d;
            mode_q    <= mode_d;
            beat_q    <= beat_d;
        end
    end

    assign eq_bits    = eq_bits_q;
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign equal      = equal_q;
    assign mismatches = mism_q;
    assign err_seen   = err_q;
    assign first_err  = first_q;

endmodule
